// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: Ram access-size codes, requester IDs
// and the default starvation limit.
package mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b11;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b00;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I/D requesters, the arbiter and the Ram.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          IReq;
  logic [AW-1:0] IAddr;
  logic          IGnt;
  logic          IValid;
  logic [DW-1:0] IRData;
  logic          IErr;

  logic          DReq;
  logic          DWr;
  logic [1:0]    DSize;
  logic [AW-1:0] DAddr;
  logic [DW-1:0] DWData;
  logic          DGnt;
  logic          DValid;
  logic [DW-1:0] DRData;
  logic          DErr;

  logic          WE;
  logic [1:0]    RWHBS;
  logic [1:0]    WWHBS;
  logic [AW-1:0] RADDR;
  logic [AW-1:0] WADDR;
  logic [DW-1:0] DIN;
  logic [DW-1:0] DOUT;
  logic          RUnalExc;
  logic          WUnalExc;

  modport slave (
    input  IReq, IAddr, DReq, DWr, DSize, DAddr, DWData, DOUT, RUnalExc, WUnalExc,
    output IGnt, IValid, IRData, IErr, DGnt, DValid, DRData, DErr,
           WE, RWHBS, WWHBS, RADDR, WADDR, DIN
  );

  modport master (
    output IReq, IAddr, DReq, DWr, DSize, DAddr, DWData, DOUT, RUnalExc, WUnalExc,
    input  IGnt, IValid, IRData, IErr, DGnt, DValid, DRData, DErr,
           WE, RWHBS, WWHBS, RADDR, WADDR, DIN
  );

endinterface

// File: rtl/mem_arb_resp.sv
// One-cycle response slice: captures Ram read data and the unaligned flag at the
// grant edge and presents them with a single-cycle valid.
module mem_arb_resp #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fire,
  input  logic          is_wr,
  input  logic [DW-1:0] rdata_in,
  input  logic          err_in,
  output logic          valid,
  output logic [DW-1:0] rdata,
  output logic          err
);

  logic          valid_q, valid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  always_comb begin
    valid_d = fire;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (fire) begin
      err_d   = err_in;
      // Writes and faulting accesses never return Ram data.
      rdata_d = (err_in || is_wr) ? '0 : rdata_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign valid = valid_q;
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester Ram arbiter: D has priority, I is forced through after STARVE_LIMIT
// consecutive D grants. Optional conflict counter behind MEM_ARB_PERF_EN.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic CLK,
  input  logic RST,
  mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] ConflictCnt
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic          d_gnt, i_gnt, d_rd, d_wr, d_err_in;
  logic [3:0]    starve_q, starve_d;
  logic [AW-1:0] raddr_q, raddr_d, waddr_q, waddr_d;
  logic [1:0]    rsize_q, rsize_d, wsize_q, wsize_d;
  logic [DW-1:0] din_q, din_d;

  always_comb begin
    d_gnt = bus.DReq && (!bus.IReq || (starve_q < LIMIT));
    i_gnt = bus.IReq && !d_gnt;
    d_rd  = d_gnt && !bus.DWr;
    d_wr  = d_gnt && bus.DWr;
  end

  // Counts D grants that overtook a waiting I; any I grant or idle I resets it.
  always_comb begin
    starve_d = starve_q;
    if (!bus.IReq || i_gnt) begin
      starve_d = '0;
    end else if (d_gnt && (starve_q < LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    raddr_d = raddr_q;
    rsize_d = rsize_q;
    waddr_d = waddr_q;
    wsize_d = wsize_q;
    din_d   = din_q;
    if (d_rd) begin
      raddr_d = bus.DAddr;
      rsize_d = bus.DSize;
    end else if (i_gnt) begin
      raddr_d = bus.IAddr;
      rsize_d = SZ_WORD;
    end
    if (d_wr) begin
      waddr_d = bus.DAddr;
      wsize_d = bus.DSize;
      din_d   = bus.DWData;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_q <= '0;
      raddr_q  <= '0;
      rsize_q  <= '0;
      waddr_q  <= '0;
      wsize_q  <= '0;
      din_q    <= '0;
    end else begin
      starve_q <= starve_d;
      raddr_q  <= raddr_d;
      rsize_q  <= rsize_d;
      waddr_q  <= waddr_d;
      wsize_q  <= wsize_d;
      din_q    <= din_d;
    end
  end

  // Address/size go to the Ram in the grant cycle itself; idle cycles replay the last value.
  assign bus.IGnt  = i_gnt;
  assign bus.DGnt  = d_gnt;
  assign bus.RADDR = raddr_d;
  assign bus.RWHBS = rsize_d;
  assign bus.WADDR = waddr_d;
  assign bus.WWHBS = wsize_d;
  assign bus.DIN   = din_d;
  assign bus.WE    = d_wr && !bus.WUnalExc;

  assign d_err_in = bus.DWr ? bus.WUnalExc : bus.RUnalExc;

  mem_arb_resp #(.DW(DW)) u_resp_i (
    .clk      (CLK),
    .rst      (RST),
    .fire     (i_gnt),
    .is_wr    (1'b0),
    .rdata_in (bus.DOUT),
    .err_in   (bus.RUnalExc),
    .valid    (bus.IValid),
    .rdata    (bus.IRData),
    .err      (bus.IErr)
  );

  mem_arb_resp #(.DW(DW)) u_resp_d (
    .clk      (CLK),
    .rst      (RST),
    .fire     (d_gnt),
    .is_wr    (bus.DWr),
    .rdata_in (bus.DOUT),
    .err_in   (d_err_in),
    .valid    (bus.DValid),
    .rdata    (bus.DRData),
    .err      (bus.DErr)
  );

`ifdef MEM_ARB_PERF_EN
  logic [31:0] conflict_q, conflict_d;

  assign conflict_d = conflict_q + {31'b0, bus.IReq & bus.DReq};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign ConflictCnt = conflict_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural little-endian Ram model.
// Build with MEM_ARB_PERF_EN to also exercise the conflict counter.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] conflict_cnt;
`endif

  mem_arbiter #(.STARVE_LIMIT(4), .AW(32), .DW(32)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .ConflictCnt (conflict_cnt)
`endif
  );

  // ---------------- Ram model ----------------
  logic [31:0] mem [0:15];

  function automatic logic unal(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  always_comb begin
    logic [31:0] w;
    logic [31:0] sh;
    w  = mem[bus.RADDR[5:2]];
    sh = 32'h0;
    case (bus.RWHBS)
      2'b00: begin
        sh = w >> {bus.RADDR[1:0], 3'b000};
        bus.DOUT = {24'h0, sh[7:0]};
      end
      2'b01: begin
        sh = w >> {bus.RADDR[1], 4'b0000};
        bus.DOUT = {16'h0, sh[15:0]};
      end
      default: bus.DOUT = w;
    endcase
    bus.RUnalExc = unal(bus.RWHBS, bus.RADDR[1:0]);
    bus.WUnalExc = unal(bus.WWHBS, bus.WADDR[1:0]);
  end

  always @(posedge clk) begin
    if (bus.WE) begin
      case (bus.WWHBS)
        2'b00:   mem[bus.WADDR[5:2]][{bus.WADDR[1:0], 3'b000} +: 8] <= bus.DIN[7:0];
        2'b01:   mem[bus.WADDR[5:2]][{bus.WADDR[1], 4'b0000} +: 16] <= bus.DIN[15:0];
        default: mem[bus.WADDR[5:2]] <= bus.DIN;
      endcase
    end
  end

  // ---------------- Scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } resp_t;

  resp_t i_q[$];
  resp_t d_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_i(input logic [31:0] data, input logic err);
    resp_t r;
    r.data = data; r.err = err; r.cyc = cyc + 1;
    i_q.push_back(r);
  endtask

  task automatic push_d(input logic [31:0] data, input logic err);
    resp_t r;
    r.data = data; r.err = err; r.cyc = cyc + 1;
    d_q.push_back(r);
  endtask

  always @(negedge clk) begin
    resp_t e;
    if (bus.IValid) begin
      if (i_q.size() == 0) begin
        chk("i_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = i_q.pop_front();
        $display("I resp cyc=%0d data=%h err=%0b", cyc, bus.IRData, bus.IErr);
        chk("i_rdata", bus.IRData, e.data);
        chk("i_err", {31'b0, bus.IErr}, {31'b0, e.err});
        chk("i_latency", cyc, e.cyc);
      end
    end
    if (bus.DValid) begin
      if (d_q.size() == 0) begin
        chk("d_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = d_q.pop_front();
        $display("D resp cyc=%0d data=%h err=%0b", cyc, bus.DRData, bus.DErr);
        chk("d_rdata", bus.DRData, e.data);
        chk("d_err", {31'b0, bus.DErr}, {31'b0, e.err});
        chk("d_latency", cyc, e.cyc);
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.IReq = 1'b0;
    bus.DReq = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ignt"},   {31'b0, bus.IGnt},   32'd0);
    chk({tag, "_dgnt"},   {31'b0, bus.DGnt},   32'd0);
    chk({tag, "_ivalid"}, {31'b0, bus.IValid}, 32'd0);
    chk({tag, "_dvalid"}, {31'b0, bus.DValid}, 32'd0);
    chk({tag, "_irdata"}, bus.IRData, 32'd0);
    chk({tag, "_drdata"}, bus.DRData, 32'd0);
    chk({tag, "_ierr"},   {31'b0, bus.IErr}, 32'd0);
    chk({tag, "_derr"},   {31'b0, bus.DErr}, 32'd0);
    chk({tag, "_we"},     {31'b0, bus.WE}, 32'd0);
    chk({tag, "_raddr"},  bus.RADDR, 32'd0);
    chk({tag, "_waddr"},  bus.WADDR, 32'd0);
    chk({tag, "_rwhbs"},  {30'b0, bus.RWHBS}, 32'd0);
    chk({tag, "_wwhbs"},  {30'b0, bus.WWHBS}, 32'd0);
    chk({tag, "_din"},    bus.DIN, 32'd0);
  endtask

  // One lone D access: expects the grant now, and a response queued for next cycle.
  task automatic d_cycle(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_data,
                         input logic exp_err, input logic exp_we);
    bus.IReq   = 1'b0;
    bus.DReq   = 1'b1;
    bus.DWr    = wr;
    bus.DSize  = sz;
    bus.DAddr  = addr;
    bus.DWData = wdata;
    @(negedge clk);
    chk("dcyc_dgnt", {31'b0, bus.DGnt}, 32'd1);
    chk("dcyc_we", {31'b0, bus.WE}, {31'b0, exp_we});
    push_d(exp_data, exp_err);
    next();
    bus.DReq = 1'b0;
  endtask

  initial begin
    bit seq_d[6];
    seq_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h1111_1111;
    idle();
    bus.IAddr = '0; bus.DWr = 1'b0; bus.DSize = 2'b11; bus.DAddr = '0; bus.DWData = '0;

    repeat (2) next();
    @(negedge clk);
    check_idle_outputs("reset");
    next();
    rst = 1'b0;
    next();

    // Lone I fetch of word 0
    bus.IReq = 1'b1; bus.IAddr = 32'h0;
    @(negedge clk);
    chk("t1_ignt", {31'b0, bus.IGnt}, 32'd1);
    chk("t1_dgnt", {31'b0, bus.DGnt}, 32'd0);
    chk("t1_rwhbs", {30'b0, bus.RWHBS}, 32'd3);
    push_i(32'h1111_1111, 1'b0);
    next();
    bus.IReq = 1'b0;

    // D write word 4 races an I fetch of the same word
    bus.DReq = 1'b1; bus.DWr = 1'b1; bus.DSize = 2'b11; bus.DAddr = 32'h4; bus.DWData = 32'h2222_2222;
    bus.IReq = 1'b1; bus.IAddr = 32'h4;
    @(negedge clk);
    chk("t2_dgnt", {31'b0, bus.DGnt}, 32'd1);
    chk("t2_ignt", {31'b0, bus.IGnt}, 32'd0);
    chk("t2_we", {31'b0, bus.WE}, 32'd1);
    chk("t2_waddr", bus.WADDR, 32'h4);
    push_d(32'h0, 1'b0);
    next();
    bus.DReq = 1'b0;
    @(negedge clk);
    chk("t2_ignt2", {31'b0, bus.IGnt}, 32'd1);
    push_i(32'h2222_2222, 1'b0);
    next();
    bus.IReq = 1'b0;

    // Both held 6 cycles: D D D D I D
    bus.DReq = 1'b1; bus.DWr = 1'b0; bus.DSize = 2'b11; bus.DAddr = 32'h0;
    bus.IReq = 1'b1; bus.IAddr = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_dgnt", {31'b0, bus.DGnt}, {31'b0, seq_d[i]});
      chk("t3_ignt", {31'b0, bus.IGnt}, {31'b0, ~seq_d[i]});
      if (seq_d[i]) push_d(32'h1111_1111, 1'b0);
      else          push_i(32'h1111_1111, 1'b0);
      next();
    end
    idle();

    // Sizes, alignment faults and write-then-read
    d_cycle(1'b0, 2'b01, 32'h5, 32'h0,         32'h0,         1'b1, 1'b0);
    d_cycle(1'b1, 2'b11, 32'h6, 32'hDEAD_BEEF, 32'h0,         1'b1, 1'b0);
    d_cycle(1'b0, 2'b11, 32'h4, 32'h0,         32'h2222_2222, 1'b0, 1'b0);
    d_cycle(1'b0, 2'b00, 32'h6, 32'h0,         32'h0000_0022, 1'b0, 1'b0);
    d_cycle(1'b0, 2'b01, 32'h2, 32'h0,         32'h0000_1111, 1'b0, 1'b0);
    d_cycle(1'b1, 2'b00, 32'h9, 32'h0000_00AB, 32'h0,         1'b0, 1'b1);
    d_cycle(1'b0, 2'b11, 32'h8, 32'h0,         32'h0000_AB00, 1'b0, 1'b0);
    d_cycle(1'b0, 2'b10, 32'h0, 32'h0,         32'h1111_1111, 1'b0, 1'b0);

    // Reset right after a D grant drops the response
    bus.DReq = 1'b1; bus.DWr = 1'b0; bus.DSize = 2'b11; bus.DAddr = 32'h0;
    @(negedge clk);
    chk("t5_dgnt", {31'b0, bus.DGnt}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.DReq = 1'b0;
    @(negedge clk);
    check_idle_outputs("rstpulse");
    next();
    rst = 1'b0;
    repeat (2) next();

`ifdef MEM_ARB_PERF_EN
    @(negedge clk);
    chk("perf_after_rst", conflict_cnt, 32'd0);
    bus.DReq = 1'b1; bus.DWr = 1'b0; bus.DSize = 2'b11; bus.DAddr = 32'h0;
    bus.IReq = 1'b1; bus.IAddr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("perf_dgnt", {31'b0, bus.DGnt}, 32'd1);
      push_d(32'h1111_1111, 1'b0);
      next();
    end
    idle();
    @(negedge clk);
    chk("perf_count3", conflict_cnt, 32'd3);
    next();
    rst = 1'b1;
    @(negedge clk);
    chk("perf_cleared", conflict_cnt, 32'd0);
    next();
    rst = 1'b0;
`endif

    repeat (3) next();
    chk("i_queue_drained", i_q.size(), 32'd0);
    chk("d_queue_drained", d_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single Ram instance (separate read/write ports, size-coded accesses, unaligned-exception flags) between two requesters: the instruction-fetch (I) and the data/load-store (D) requester.
- Uses a request/grant handshake with registered one-cycle responses.
- Arbitration: D has priority, with a starvation guard for I.
- Sits between the pipeline's IF/MEM stages and the Ram.

Parameters:
- STARVE_LIMIT, 4: max consecutive D grants while IReq is pending before I is forced a grant. Legal range 1..15.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- IReq  in  1  instruction read request; held with stable IAddr until IGnt.
- IAddr  in  AW  instruction byte address; always a word access.
- IGnt  out  1  I request accepted this cycle (combinational).
- IValid  out  1  I response valid (registered).
- IRData  out  DW  I read data.
- IErr  out  1  I unaligned-read exception.
- DReq  in  1  data request; held with DWr/DSize/DAddr/DWData stable until DGnt.
- DWr  in  1  1 = write, 0 = read.
- DSize  in  2  11 = word, 01 = half, 00 = byte, 10 = reserved (treated as word).
- DAddr  in  AW  data byte address.
- DWData  in  DW  write data, right-aligned.
- DGnt  out  1  D request accepted this cycle (combinational).
- DValid  out  1  D response valid (registered); issued for both reads and writes.
- DRData  out  DW  D read data.
- DErr  out  1  D unaligned exception (read or write).
- WE  out  1  Ram write enable.
- RWHBS  out  2  Ram read size.
- WWHBS  out  2  Ram write size.
- RADDR  out  AW  Ram read address.
- WADDR  out  AW  Ram write address.
- DIN  out  DW  Ram write data.
- DOUT  in  DW  Ram read data (combinational from RADDR/RWHBS).
- RUnalExc  in  1  Ram read unaligned flag.
- WUnalExc  in  1  Ram write unaligned flag.

Behaviour:
- Reset: all outputs and registers 0. The starvation counter clears; pending responses are discarded. RST asserted mid-access drops the response, and no Valid appears after RST deasserts.
- Grant rule (combinational, one grant per cycle):
  - If DReq and (not IReq or StarveCnt < STARVE_LIMIT): DGnt = 1.
  - Else if IReq: IGnt = 1.
  - At most one of IGnt/DGnt is high.
- StarveCnt (4 bit):
  - Increments on DGnt while IReq is high; saturates at STARVE_LIMIT.
  - Clears on IGnt, or on any cycle with IReq low.
- Ram drive in the grant cycle:
  - D read: RADDR = DAddr, RWHBS = DSize.
  - I read: RADDR = IAddr, RWHBS = 11.
  - D write: WADDR = DAddr, WWHBS = DSize, DIN = DWData, WE = DGnt & DWr & ~WUnalExc.
  - No grant: WE = 0; RADDR/RWHBS hold the last value (don't care).
  - Unaligned writes never reach the Ram.
- Responses:
  - On the cycle after a grant, the granted side's Valid = 1 for exactly one cycle.
  - RData = DOUT captured at the grant cycle's clock edge; Err = RUnalExc (read) or WUnalExc (write) captured the same way.
  - On error, or on a write, RData = 0.
- Latency: grant at cycle N, Valid/RData/Err at N+1. Back-to-back grants give one response per cycle.
- Simultaneous requests with StarveCnt < STARVE_LIMIT: D wins and I stalls. When the limit is reached, I wins once and the counter clears.
- Write followed by a read of the same address in the next cycle returns the new data (the Ram write completes at the grant edge).

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined: adds output ConflictCnt (32 bit), which increments in every cycle with IReq & DReq. It wraps at 2^32 and clears on RST.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package mem_pkg holds:
  - size constants SZ_WORD = 2'b11, SZ_HALF = 2'b01, SZ_BYTE = 2'b00;
  - requester IDs REQ_I/REQ_D;
  - STARVE_LIMIT default.
- One sub-module, mem_arb_resp: a response register slice (Valid/RData/Err) instantiated once per requester.

Test Plan:
- Ram word 0 = 0x11111111. IReq = 1, IAddr = 0 alone → IGnt = 1 in the same cycle; next cycle IValid = 1, IRData = 0x11111111, IErr = 0.
- DReq write word, DAddr = 4, DWData = 0x22222222, together with IReq, IAddr = 4 → DGnt first, DValid next cycle. IGnt occurs one cycle later, and IRData = 0x22222222.
- DReq and IReq held continuously for 6 cycles, STARVE_LIMIT = 4 → grant sequence D, D, D, D, I, D.
- DReq half read at DAddr = 5 → DValid = 1, DErr = 1, DRData = 0. DReq word write at DAddr = 6 → WE stays 0 and Ram word 4 is unchanged.
- RST pulsed in the cycle after DGnt → DValid never asserts, and all outputs are 0 one cycle later.
- With MEM_ARB_PERF_EN, 3 conflict cycles → ConflictCnt = 3; after RST, ConflictCnt = 0.
